// File: rtl/tetrimino_spawner_if.sv
// Spawn request / board bundle between playfield FSM and spawner.
// master drives requests and board snapshots; slave is the spawner.
interface tetrimino_spawner_if #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
);
  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int NW = BOARD_W * BOARD_H;

  logic            spawn_req;
  logic            force_en;
  logic [2:0]      force_piece;
  logic            game_restart;
  logic [NW-1:0]   board_in;
  logic [NW-1:0]   board_out;
  logic            busy;
  logic            spawn_done;
  logic            game_over;
  logic [2:0]      piece_id;
  logic [4*XW-1:0] cell_x;
  logic [4*YW-1:0] cell_y;
  logic [2:0]      next_piece;

  modport master (
    output spawn_req, force_en, force_piece,
    output game_restart, board_in,
    input  board_out, busy, spawn_done, game_over,
    input  piece_id, cell_x, cell_y, next_piece
  );

  modport slave (
    input  spawn_req, force_en, force_piece,
    input  game_restart, board_in,
    output board_out, busy, spawn_done, game_over,
    output piece_id, cell_x, cell_y, next_piece
  );
endinterface

// File: rtl/tetrimino_spawner.sv
// Tetrimino spawner: LFSR/forced piece pick, spawn collision check,
// board merge or sticky game-over, one-deep next-piece preview.
module tetrimino_spawner #(
  parameter int          BOARD_W   = 10,
  parameter int          BOARD_H   = 20,
  parameter int          SPAWN_COL = 3,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic clk,
  input logic rst_n,
  tetrimino_spawner_if.slave sp
);
  localparam int XW = $clog2(BOARD_W);
  localparam int YW = $clog2(BOARD_H);
  localparam int NW = BOARD_W * BOARD_H;
  localparam int IW = $clog2(NW);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_COMMIT, S_REFILL, S_OVER
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [NW-1:0]   snap_q, snap_d;
  logic [2:0]      piece_q, piece_d;
  logic            forced_q, forced_d;
  logic [NW-1:0]   board_q, board_d;
  logic            done_q, done_d;
  logic            over_q, over_d;
  logic [2:0]      id_q, id_d;
  logic [4*XW-1:0] cx_q, cx_d;
  logic [4*YW-1:0] cy_q, cy_d;
  logic [2:0]      next_q, next_d;

  logic [7:0]      dx;
  logic [3:0]      dy;
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic [4*XW-1:0] cx_pk;
  logic [4*YW-1:0] cy_pk;
  logic [NW-1:0]   mask;
  logic            use_force;

  // dx packs 2 bits per cell, dy 1 bit per cell; cell0 in the LSBs
  always_comb begin
    dx = 8'h00;
    dy = 4'b0000;
    unique case (piece_q)
      3'd0: begin dx = {2'd3, 2'd2, 2'd1, 2'd0}; dy = 4'b0000; end
      3'd1: begin dx = {2'd2, 2'd1, 2'd2, 2'd1}; dy = 4'b1100; end
      3'd2: begin dx = {2'd2, 2'd1, 2'd0, 2'd1}; dy = 4'b1110; end
      3'd3: begin dx = {2'd1, 2'd0, 2'd2, 2'd1}; dy = 4'b1100; end
      3'd4: begin dx = {2'd2, 2'd1, 2'd1, 2'd0}; dy = 4'b1100; end
      3'd5: begin dx = {2'd2, 2'd1, 2'd0, 2'd0}; dy = 4'b1110; end
      3'd6: begin dx = {2'd2, 2'd1, 2'd0, 2'd2}; dy = 4'b1110; end
      default: begin dx = {2'd3, 2'd2, 2'd1, 2'd0}; dy = 4'b0000; end
    endcase
  end

  always_comb begin
    mask  = '0;
    cx_pk = '0;
    cy_pk = '0;
    cx    = '0;
    cy    = '0;
    for (int i = 0; i < 4; i++) begin
      cx = XW'(SPAWN_COL) + XW'(dx[2*i +: 2]);
      cy = YW'(dy[i]);
      cx_pk[i*XW +: XW] = cx;
      cy_pk[i*YW +: YW] = cy;
      mask[IW'(int'(cy) * BOARD_W + int'(cx))] = 1'b1;
    end
  end

  assign use_force = sp.force_en && (sp.force_piece != 3'd7);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    snap_d   = snap_q;
    piece_d  = piece_q;
    forced_d = forced_q;
    board_d  = board_q;
    done_d   = 1'b0;
    over_d   = over_q;
    id_d     = id_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    next_d   = next_q;
    if (sp.game_restart) begin
      state_d = S_IDLE;
      over_d  = 1'b0;
      board_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sp.spawn_req) begin
            snap_d   = sp.board_in;
            forced_d = use_force;
            piece_d  = use_force ? sp.force_piece : next_q;
            state_d  = S_CHECK;
          end
        end
        S_CHECK: begin
          if (|(snap_q & mask)) begin
            over_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            board_d = snap_q | mask;
            id_d    = piece_q;
            cx_d    = cx_pk;
            cy_d    = cy_pk;
            done_d  = 1'b1;
            state_d = S_COMMIT;
          end
        end
        S_COMMIT: state_d = forced_q ? S_IDLE : S_REFILL;
        S_REFILL: begin
          if (lfsr_q[2:0] != 3'd7) begin
            next_d  = lfsr_q[2:0];
            state_d = S_IDLE;
          end
        end
        S_OVER:  state_d = S_OVER;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      snap_q   <= '0;
      piece_q  <= '0;
      forced_q <= 1'b0;
      board_q  <= '0;
      done_q   <= 1'b0;
      over_q   <= 1'b0;
      id_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      next_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      snap_q   <= snap_d;
      piece_q  <= piece_d;
      forced_q <= forced_d;
      board_q  <= board_d;
      done_q   <= done_d;
      over_q   <= over_d;
      id_q     <= id_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      next_q   <= next_d;
    end
  end

  assign sp.board_out  = board_q;
  assign sp.busy       = (state_q == S_CHECK) || (state_q == S_COMMIT) ||
                         (state_q == S_REFILL);
  assign sp.spawn_done = done_q;
  assign sp.game_over  = over_q;
  assign sp.piece_id   = id_q;
  assign sp.cell_x     = cx_q;
  assign sp.cell_y     = cy_q;
  assign sp.next_piece = next_q;
endmodule

// File: tb/tb_tetrimino_spawner.sv
// Scoreboard bench for tetrimino_spawner: timed reference model,
// randomized spawns, collision/restart and a parameter sweep.
module tb_tetrimino_spawner;
  localparam int W = 10, H = 20, SC = 3, NW = W * H, XW = 4, YW = 5;
  localparam int W2 = 12, H2 = 24, NW2 = W2 * H2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int TABN = 60000;

  localparam int DX [7][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{1,0,1,2},
    '{1,2,0,1}, '{0,1,1,2}, '{0,0,1,2}, '{2,0,1,2}};
  localparam int DY [7][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,1,1,1},
    '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}, '{0,1,1,1}};

  typedef struct {
    int              at;
    logic [2:0]      id;
    logic [4*XW-1:0] cx;
    logic [4*YW-1:0] cy;
    logic [NW-1:0]   brd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tetrimino_spawner_if #(.BOARD_W(W), .BOARD_H(H)) sp ();
  tetrimino_spawner_if #(.BOARD_W(W2), .BOARD_H(H2)) sp2 ();

  tetrimino_spawner #(.BOARD_W(W), .BOARD_H(H), .SPAWN_COL(SC),
    .SEED(SEED)) dut (.clk(clk), .rst_n(rst_n), .sp(sp));
  tetrimino_spawner #(.BOARD_W(W2), .BOARD_H(H2), .SPAWN_COL(5),
    .SEED(SEED)) dut2 (.clk(clk), .rst_n(rst_n), .sp(sp2));

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  int done_cnt = 0;
  int idle_at = 0;
  logic [15:0] tab [TABN];
  logic [2:0] mnext;
  logic [NW-1:0] mboard;
  logic [6:0] seen;
  exp_t q [$];
  logic [2:0] ids [$];
  logic [2:0] run1 [$];

  always @(posedge clk) begin
    if (!rst_n) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] pmask(int p);
    logic [NW-1:0] m = '0;
    for (int i = 0; i < 4; i++) m[DY[p][i] * W + SC + DX[p][i]] = 1'b1;
    return m;
  endfunction

  function automatic logic [NW-1:0] rnd_board();
    logic [NW-1:0] b = '0;
    for (int i = 0; i < NW; i++) b[i] = ($urandom_range(0, 7) == 0);
    return b;
  endfunction

  // first REFILL edge (>= acceptance+3) whose LFSR low bits are not 7
  function automatic int refill_edge(int a);
    int r = a + 3;
    while (r < TABN - 1 && tab[r][2:0] == 3'd7) r++;
    return r;
  endfunction

  function automatic exp_t mk_exp(int at, int p, logic [NW-1:0] brd);
    exp_t e;
    e.at = at;
    e.id = 3'(p);
    e.cx = '0;
    e.cy = '0;
    for (int i = 0; i < 4; i++) begin
      e.cx[i*XW +: XW] = XW'(SC + DX[p][i]);
      e.cy[i*YW +: YW] = YW'(DY[p][i]);
    end
    e.brd = brd | pmask(p);
    return e;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sp.spawn_done) begin
        done_cnt++;
        ids.push_back(sp.piece_id);
        if (sp.piece_id < 3'd7) seen[sp.piece_id] = 1'b1;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got piece %0d expected none",
                   sp.piece_id);
        end else begin
          e = q.pop_front();
          chk("done_time", ecnt, e.at);
          chk("piece_id", sp.piece_id, e.id);
          chk("cell_x", sp.cell_x, e.cx);
          chk("cell_y", sp.cell_y, e.cy);
          chk("board_out", sp.board_out, e.brd);
        end
      end
    end
  end

  task automatic go_idle();
    while (ecnt < idle_at) @(negedge clk);
    chk("idle_busy", sp.busy, 0);
    chk("next_piece", sp.next_piece, mnext);
  endtask

  task automatic spawn(bit fe, logic [2:0] fp, logic [NW-1:0] brd,
                       output bit col);
    int a, r, p;
    bit frc;
    go_idle();
    a = ecnt;
    sp.spawn_req = 1'b1;
    sp.force_en = fe;
    sp.force_piece = fp;
    sp.board_in = brd;
    @(negedge clk);
    sp.spawn_req = 1'b0;
    sp.force_en = 1'($urandom);
    sp.force_piece = 3'($urandom);
    sp.board_in = rnd_board();
    frc = fe && fp != 3'd7;
    p = frc ? int'(fp) : int'(mnext);
    col = |(pmask(p) & brd);
    chk("busy_check", sp.busy, 1);
    if (col) begin
      @(negedge clk);
      chk("over_flag", sp.game_over, 1);
      chk("over_busy", sp.busy, 0);
      chk("over_board", sp.board_out, mboard);
    end else begin
      q.push_back(mk_exp(a + 2, p, brd));
      mboard = brd | pmask(p);
      if (frc) idle_at = a + 3;
      else begin
        r = refill_edge(a);
        mnext = tab[r][2:0];
        idle_at = r + 1;
      end
    end
  endtask

  task automatic restart();
    sp.game_restart = 1'b1;
    @(negedge clk);
    sp.game_restart = 1'b0;
    mboard = '0;
    idle_at = ecnt;
    chk("rst_over", sp.game_over, 0);
    chk("rst_board", sp.board_out, 0);
    chk("rst_busy", sp.busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mnext = 3'd0;
    mboard = '0;
    idle_at = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit col;
    int a, acc, r, nexp, d0, diff;
    logic [NW-1:0] b;
    logic [NW2-1:0] b2;
    sp.spawn_req = 1'b0; sp.force_en = 1'b0; sp.force_piece = 3'd0;
    sp.game_restart = 1'b0; sp.board_in = '0;
    sp2.spawn_req = 1'b0; sp2.force_en = 1'b0; sp2.force_piece = 3'd0;
    sp2.game_restart = 1'b0; sp2.board_in = '0;
    seen = '0;
    mnext = 3'd0;
    mboard = '0;
    tab[0] = SEED;
    for (int i = 1; i < TABN; i++)
      tab[i] = {1'b0, tab[i-1][15:1]} ^ (tab[i-1][0] ? 16'hB400 : 16'h0);

    sp.spawn_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_done", sp.spawn_done, 0);
    end
    chk("reset_busy", sp.busy, 0);
    chk("reset_over", sp.game_over, 0);
    chk("reset_board", sp.board_out, 0);
    chk("reset_id", sp.piece_id, 0);
    chk("reset_cx", sp.cell_x, 0);
    chk("reset_cy", sp.cell_y, 0);
    chk("reset_next", sp.next_piece, 0);
    sp.spawn_req = 1'b0;
    rst_n = 1'b1;

    spawn(1'b1, 3'd2, '0, col);
    @(negedge clk);
    chk("t_done", sp.spawn_done, 1);
    b = '0;
    b[4] = 1'b1; b[13] = 1'b1; b[14] = 1'b1; b[15] = 1'b1;
    chk("t_board", sp.board_out, b);
    chk("t_cx", sp.cell_x, {4'd5, 4'd4, 4'd3, 4'd4});
    chk("t_cy", sp.cell_y, {5'd1, 5'd1, 5'd1, 5'd0});
    go_idle();
    restart();

    b = '0;
    b[14] = 1'b1;
    spawn(1'b1, 3'd1, b, col);
    chk("o_collide", col, 1);
    sp.spawn_req = 1'b1;
    repeat (2) @(negedge clk);
    sp.spawn_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("over_sticky", sp.game_over, 1);
    chk("over_idle_busy", sp.busy, 0);
    restart();

    go_idle();
    a = ecnt;
    acc = a;
    nexp = 0;
    d0 = done_cnt;
    sp.spawn_req = 1'b1;
    sp.force_en = 1'b0;
    sp.board_in = '0;
    while (acc <= a + 5) begin
      q.push_back(mk_exp(acc + 2, int'(mnext), '0));
      r = refill_edge(acc);
      mnext = tab[r][2:0];
      idle_at = r + 1;
      acc = r + 1;
      nexp++;
    end
    while (ecnt < a + 6) @(negedge clk);
    sp.spawn_req = 1'b0;
    while (ecnt < idle_at || ecnt < a + 8) @(negedge clk);
    chk("held_dones", done_cnt - d0, nexp);
    mboard = pmask(int'(ids[ids.size()-1]));

    for (int run = 0; run < 2; run++) begin
      do_reset();
      ids.delete();
      seen = '0;
      for (int k = 0; k < 2000; k++) spawn(1'b0, 3'($urandom), '0, col);
      go_idle();
      chk("stream_sb_empty", q.size(), 0);
      chk("stream_all_ids", seen, 7'h7f);
      if (run == 0) run1 = ids;
    end
    diff = (run1.size() == ids.size()) ? 0 : 1;
    for (int k = 0; k < run1.size() && k < ids.size(); k++)
      if (run1[k] != ids[k]) diff++;
    chk("stream_repeat", diff, 0);
    chk("stream_len", ids.size(), 2000);

    for (int k = 0; k < 300; k++) begin
      spawn(1'($urandom), 3'($urandom), rnd_board(), col);
      if (col) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        restart();
      end
    end
    go_idle();
    chk("mix_sb_empty", q.size(), 0);

    sp2.spawn_req = 1'b1; sp2.force_en = 1'b1; sp2.force_piece = 3'd0;
    @(negedge clk);
    sp2.spawn_req = 1'b0;
    @(negedge clk);
    chk("sw_i_done", sp2.spawn_done, 1);
    b2 = '0;
    for (int i = 5; i <= 8; i++) b2[i] = 1'b1;
    chk("sw_i_board", sp2.board_out, b2);
    chk("sw_i_cx", sp2.cell_x, {4'd8, 4'd7, 4'd6, 4'd5});
    chk("sw_i_cy", sp2.cell_y, 0);
    @(negedge clk);
    sp2.spawn_req = 1'b1; sp2.force_piece = 3'd6;
    @(negedge clk);
    sp2.spawn_req = 1'b0;
    @(negedge clk);
    b2 = '0;
    b2[7] = 1'b1; b2[17] = 1'b1; b2[18] = 1'b1; b2[19] = 1'b1;
    chk("sw_l_board", sp2.board_out, b2);
    chk("sw_l_cx", sp2.cell_x, {4'd7, 4'd6, 4'd5, 4'd7});
    chk("sw_l_cy", sp2.cell_y, {5'd1, 5'd1, 5'd1, 5'd0});
    chk("sw_l_id", sp2.piece_id, 6);

    repeat (4) @(negedge clk);
    chk("final_sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tetrimino_spawner.md
# tetrimino_spawner

Parametrised piece spawner for the playfield state machine. On request it picks the next tetrimino from a free-running LFSR, or takes a forced piece, and checks its spawn cells against a snapshot of the board. It then either merges the piece into the board or raises a sticky game-over. A one-deep next-piece preview is held for the display path.

## Interface
- BOARD_W, 10, playfield width in cells (must be ≥ SPAWN_COL+4)
- BOARD_H, 20, playfield height in cells (must be ≥ 2)
- SPAWN_COL, 3, x of the left column of the 4x2 spawn box
- SEED, 16'hACE1, LFSR reset value (must be nonzero)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- spawn_req  in  1  spawn request; sampled only in IDLE
- force_en  in  1  when high at acceptance, spawn force_piece instead of next_piece
- force_piece  in  3  forced piece id 0..6; value 7 means "use next_piece"
- game_restart  in  1  clears game_over and board_out, returns to IDLE
- board_in  in  BOARD_W*BOARD_H  occupancy; cell (x,y) at bit y*BOARD_W+x, y=0 is the top row
- board_out  out  BOARD_W*BOARD_H  registered board after the last commit
- busy  out  1  high in every state except IDLE and OVER
- spawn_done  out  1  one-cycle pulse; the commit has landed in board_out
- game_over  out  1  sticky; spawn collided
- piece_id  out  3  id of the last committed piece
- cell_x  out  4*XW  x of the 4 committed cells, cell0 in the LSBs; XW=$clog2(BOARD_W)
- cell_y  out  4*YW  y of the 4 committed cells; YW=$clog2(BOARD_H)
- next_piece  out  3  preview id, always 0..6

## Operation
- Piece ids and spawn offsets (dx,dy) relative to (SPAWN_COL,0), listed in cell0..cell3 order:
  - 0 I: (0,0)(1,0)(2,0)(3,0)
  - 1 O: (1,0)(2,0)(1,1)(2,1)
  - 2 T: (1,0)(0,1)(1,1)(2,1)
  - 3 S: (1,0)(2,0)(0,1)(1,1)
  - 4 Z: (0,0)(1,0)(1,1)(2,1)
  - 5 J: (0,0)(0,1)(1,1)(2,1)
  - 6 L: (2,0)(0,1)(1,1)(2,1)
- LFSR: 16-bit Galois, taps mask 16'hB400, shifts right every cycle in every state. It loads SEED on reset only; game_restart does not reseed it.
- FSM states: IDLE, CHECK, COMMIT, REFILL, OVER.
- IDLE: if spawn_req is high, accept the request:
  - latch board_in into a snapshot;
  - latch the active piece: force_piece if force_en=1 and force_piece≠7, else next_piece;
  - latch a "forced" flag;
  - go to CHECK.
- CHECK: compute the 4 cell positions. Collision = any of those snapshot bits set. On collision go to OVER, else go to COMMIT.
- COMMIT:
  - board_out ← snapshot OR piece mask;
  - update piece_id, cell_x and cell_y;
  - pulse spawn_done;
  - if the forced flag is set go to IDLE (next_piece is not consumed), else go to REFILL.
- REFILL: if lfsr[2:0]≠7, next_piece ← lfsr[2:0] and go to IDLE; otherwise stay in REFILL and retry next cycle.
- OVER: set game_over; board_out, piece_id and the cell outputs stay unchanged; no spawn_done. Stay in OVER until game_restart.
- Priority: rst_n low > game_restart > FSM.
  - game_restart in any state: state ← IDLE, game_over ← 0, board_out ← 0, spawn_done ← 0.
  - next_piece and the LFSR are kept.
- spawn_req outside IDLE is ignored and not queued.

## Timing
- Reset values: state IDLE, busy 0, spawn_done 0, game_over 0, board_out all 0, piece_id 0, cell_x/cell_y 0, next_piece 0 (I), LFSR = SEED.
- Request accepted at edge N (IDLE, spawn_req=1) ⇒ busy=1 from N+1, CHECK during cycle N+1, and spawn_done=1 with the new board_out during cycle N+2.
- Unforced spawn: REFILL during N+3 or later. busy drops the cycle after REFILL exits, so the earliest next acceptance is edge N+4.
- Forced spawn: back in IDLE at N+3; next acceptance at edge N+3.
- Collision: OVER entered at N+2, game_over=1 from N+2 onward, busy=0 in OVER.
- board_in may change freely after the acceptance edge; only the snapshot is used.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with spawn_req=1 ⇒ all outputs at their reset values, next_piece=0, no spawn_done.
- Forced T, empty board, defaults: force_en=1, force_piece=2, spawn_req pulse ⇒ spawn_done 2 cycles later; board_out has exactly bits 4,13,14,15 set; cell_x=(4,3,4,5), cell_y=(0,1,1,1); next_piece unchanged.
- Collision: board_in bit 14 set, forced O ⇒ game_over=1 at acceptance+2, no spawn_done, board_out still 0. A further spawn_req is ignored. game_restart ⇒ game_over=0, IDLE.
- Busy rejection: spawn_req held high for 6 cycles on an empty board with unforced spawns ⇒ exactly one spawn_done per accepted request, with acceptances at least 4 cycles apart. A request asserted during CHECK or REFILL is not queued.
- Random stream: 2000 unforced spawns with board_in=0 each time ⇒ piece_id never 7, all ids 0..6 appear, each spawn_done's cells match the table, and the sequence is identical across two runs with the same SEED.
- Parameter sweep: BOARD_W=12, BOARD_H=24, SPAWN_COL=5, forced I ⇒ board_out bits 5..8 set, cell_x=(5,6,7,8), cell_y all 0.
